// File: rtl/game_ctrl.sv
// Frogger game-flow controller: game state, level, frog row, BCD score and sound requests.
// Optional high-score register enabled by defining GAME_CTRL_HISCORE_EN.
module game_ctrl #(
   parameter int ROWS        = 13,
   parameter int MAX_LEVEL   = 9,
   parameter int DEAD_FRAMES = 120,
   parameter int WIN_FRAMES  = 180,
   parameter int LEVEL_BONUS = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        btn_up_tick,
   input  logic        btn_down_tick,
   input  logic        btn_any_tick,
   input  logic        frame_tick,
   input  logic        collision,
   output logic [1:0]  state,
   output logic [3:0]  level,
   output logic [3:0]  frog_row,
   output logic [11:0] score_bcd,
   output logic [11:0] hiscore_bcd,
   output logic        snd_req,
   output logic [1:0]  snd_type,
   input  logic        snd_ack
);

   typedef enum logic [1:0] {MENU = 2'd0, PLAYING = 2'd1, DEAD = 2'd2, WIN = 2'd3} state_t;

   localparam logic [1:0] SND_PRESS = 2'd0;
   localparam logic [1:0] SND_NEXT  = 2'd1;
   localparam logic [1:0] SND_CRASH = 2'd2;
   localparam logic [1:0] SND_CELEB = 2'd3;

   localparam int MAXF = (DEAD_FRAMES > WIN_FRAMES) ? DEAD_FRAMES : WIN_FRAMES;
   localparam int TW   = $clog2(MAXF + 1);
   localparam int GOAL_ADD = LEVEL_BONUS + 1;
   // Goal reward (+1 row, +bonus) pre-encoded as BCD so one adder handles every score update.
   localparam logic [11:0] GOAL_BCD = {4'(GOAL_ADD / 100), 4'((GOAL_ADD / 10) % 10), 4'(GOAL_ADD % 10)};
   localparam logic [3:0]  TOP_ROW   = 4'(ROWS - 1);
   localparam logic [3:0]  LAST_LVL  = 4'(MAX_LEVEL);
   localparam logic [TW-1:0] DEAD_LAST = TW'(DEAD_FRAMES - 1);
   localparam logic [TW-1:0] WIN_LAST  = TW'(WIN_FRAMES - 1);

   function automatic logic [11:0] bcd_add(input logic [11:0] a, input logic [11:0] b);
      logic [4:0]  d;
      logic        c;
      logic [11:0] s;
      c = 1'b0;
      s = '0;
      for (int i = 0; i < 3; i++) begin
         d = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]} + {4'd0, c};
         c = (d > 5'd9);
         if (c) d = d - 5'd10;
         s[i*4 +: 4] = d[3:0];
      end
      return c ? 12'h999 : s;
   endfunction

   state_t          state_q, state_d;
   logic [3:0]      level_q, level_d, row_q, row_d, max_row_q, max_row_d, up_row;
   logic [11:0]     score_q, score_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic            snd_req_q, snd_req_d, ev;
   logic [1:0]      snd_type_q, snd_type_d, ev_type;

   assign up_row = row_q + 4'd1;

   always_comb begin
      state_d   = state_q;
      level_d   = level_q;
      row_d     = row_q;
      max_row_d = max_row_q;
      score_d   = score_q;
      timer_d   = timer_q;
      ev        = 1'b0;
      ev_type   = SND_PRESS;
      case (state_q)
         MENU: begin
            row_d     = '0;
            max_row_d = '0;
            level_d   = 4'd1;
            score_d   = '0;
            if (btn_any_tick) begin
               state_d = PLAYING;
               ev      = 1'b1;
               ev_type = SND_PRESS;
            end
         end
         PLAYING: begin
            if (collision) begin
               state_d = DEAD;
               timer_d = '0;
               ev      = 1'b1;
               ev_type = SND_CRASH;
            end else if (btn_up_tick && !btn_down_tick) begin
               if (row_q < TOP_ROW) begin
                  row_d = up_row;
                  if (up_row == TOP_ROW) begin
                     score_d   = bcd_add(score_q, GOAL_BCD);
                     max_row_d = up_row;
                     ev        = 1'b1;
                     if (level_q == LAST_LVL) begin
                        state_d = WIN;
                        timer_d = '0;
                        ev_type = SND_CELEB;
                     end else begin
                        level_d   = level_q + 4'd1;
                        row_d     = '0;
                        max_row_d = '0;
                        ev_type   = SND_NEXT;
                     end
                  end else if (up_row > max_row_q) begin
                     max_row_d = up_row;
                     score_d   = bcd_add(score_q, 12'h001);
                  end
               end
            end else if (btn_down_tick && !btn_up_tick && row_q != 4'd0) begin
               row_d = row_q - 4'd1;
            end
         end
         default: begin
            // DEAD and WIN share the frame countdown; the completing tick returns to MENU.
            if (frame_tick) begin
               if (timer_q == ((state_q == DEAD) ? DEAD_LAST : WIN_LAST)) begin
                  state_d   = MENU;
                  timer_d   = '0;
                  row_d     = '0;
                  max_row_d = '0;
                  level_d   = 4'd1;
                  score_d   = '0;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
         end
      endcase
      snd_req_d  = ev | (snd_req_q & ~snd_ack);
      snd_type_d = ev ? ev_type : snd_type_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= MENU;
         level_q    <= 4'd1;
         row_q      <= '0;
         max_row_q  <= '0;
         score_q    <= '0;
         timer_q    <= '0;
         snd_req_q  <= 1'b0;
         snd_type_q <= SND_PRESS;
      end else begin
         state_q    <= state_d;
         level_q    <= level_d;
         row_q      <= row_d;
         max_row_q  <= max_row_d;
         score_q    <= score_d;
         timer_q    <= timer_d;
         snd_req_q  <= snd_req_d;
         snd_type_q <= snd_type_d;
      end
   end

`ifdef GAME_CTRL_HISCORE_EN
   logic [11:0] hiscore_q;
   // Packed valid BCD orders the same as binary, so a plain compare works.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  hiscore_q <= '0;
      else if (score_q > hiscore_q) hiscore_q <= score_q;
   end
   assign hiscore_bcd = hiscore_q;
`else
   assign hiscore_bcd = 12'h000;
`endif

   assign state     = state_q;
   assign level     = level_q;
   assign frog_row  = row_q;
   assign score_bcd = score_q;
   assign snd_req   = snd_req_q;
   assign snd_type  = snd_type_q;

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Game-flow controller for the Frogger display path. It owns the game state (MENU/PLAYING/DEAD/WIN), the level counter, frog row progress, and score/high score. Score and high score are kept as packed BCD, so the text overlay needs no dividers. It also issues one-at-a-time sound event requests. It consumes debounced button tick pulses, a per-frame tick and a collision flag, and drives the `state`, `level` and score inputs of the UI text overlay.

## Interface
Parameters:
- `ROWS`, 13: number of lanes. Row 0 is the start row; row `ROWS-1` is the goal row.
- `MAX_LEVEL`, 9: last level. Clearing it wins the game. Range 1..9.
- `DEAD_FRAMES`, 120: `frame_tick` count spent in DEAD.
- `WIN_FRAMES`, 180: `frame_tick` count spent in WIN.
- `LEVEL_BONUS`, 10: score added per cleared level. Range 0..99.

Ports (clock and reset first):
- `clk`, in, 1: system clock. One clock; all state changes on the rising edge.
- `rst_n`, in, 1: reset. Asynchronous, active-low.
- `btn_up_tick`, in, 1: one-cycle pulse, up button.
- `btn_down_tick`, in, 1: one-cycle pulse, down button.
- `btn_any_tick`, in, 1: one-cycle pulse, any button.
- `frame_tick`, in, 1: one-cycle pulse per video frame.
- `collision`, in, 1: level signal from the playfield; high means the frog is overlapping a hazard.
- `state`, out, 2: game state. MENU=0, PLAYING=1, DEAD=2, WIN=3.
- `level`, out, 4: current level, binary, 1..`MAX_LEVEL`.
- `frog_row`, out, 4: current frog row, 0..`ROWS-1`.
- `score_bcd`, out, 12: score as three BCD digits; the high nibble is hundreds.
- `hiscore_bcd`, out, 12: high score as three BCD digits.
- `snd_req`, out, 1: sound request valid.
- `snd_type`, out, 2: sound event. UI_PRESS=0, NEXTLEVEL=1, CRASH=2, CELEBRATION=3.
- `snd_ack`, in, 1: sound player accepts the event.

## Operation
- Reset values: `state`=MENU, `level`=1, `frog_row`=0, `score_bcd`=0, `hiscore_bcd`=0, `snd_req`=0, `snd_type`=0. The internal `max_row` and the frame timer are also reset to 0.
- **MENU:**
  - Each cycle: hold `frog_row`=0, `max_row`=0, `level`=1, `score`=0.
  - `btn_any_tick` → go to PLAYING and raise sound event UI_PRESS.
- **PLAYING**, evaluated in this priority order:
  1. `collision`=1 → go to DEAD, raise CRASH, clear the timer. Buttons are ignored that cycle.
  2. `btn_up_tick` and `btn_down_tick` both high in the same cycle → no action.
  3. `btn_up_tick` with `frog_row` < `ROWS-1`:
     - `frog_row`+1.
     - If the new row > `max_row`: `max_row` = new row and score +1.
  4. `btn_down_tick` with `frog_row` > 0 → `frog_row`−1. No score change. At row 0 the tick is ignored.
  5. Up move lands on `ROWS-1` (goal):
     - Score +1 (new row) and +`LEVEL_BONUS`, applied in the same update.
     - If `level`==`MAX_LEVEL`: go to WIN, raise CELEBRATION, clear the timer; `frog_row` stays at `ROWS-1`.
     - Otherwise: `level`+1, `frog_row`=0, `max_row`=0, raise NEXTLEVEL, stay in PLAYING.
- **DEAD:**
  - The timer counts `frame_tick` pulses; all buttons are ignored.
  - At count `DEAD_FRAMES` → go to MENU.
- **WIN:**
  - Same as DEAD, using `WIN_FRAMES`.
- **Score arithmetic:**
  - BCD add with per-digit carry.
  - Saturates at 999; there is no wrap.
- **Sound handshake:**
  - Raising an event sets `snd_req`=1 and loads `snd_type`.
  - `snd_req` holds until a cycle where `snd_ack`=1 and no new event is raised; it falls on the next edge.
  - A new event while `snd_req`=1 overwrites `snd_type`; `snd_req` stays 1.
  - A new event in the same cycle as `snd_ack`: the old event counts as consumed, the new one is loaded, and `snd_req` stays 1.
  - `snd_ack` while `snd_req`=0 is ignored.
  - Sound requests are independent of state; reaching MENU does not clear a pending request.

## Timing
- All outputs are registered. A qualifying input in cycle N is visible on the outputs in cycle N+1.
- `state`, `frog_row`, `score_bcd`, `level` and the sound request update on the same edge.
- `hiscore_bcd` follows `score_bcd` one cycle later.
- DEAD lasts exactly `DEAD_FRAMES` `frame_tick` pulses. The pulse that completes the count causes the transition on that edge.
- `rst_n` asserted mid-operation (any state, pending sound request): outputs go to reset values immediately, with no dependence on `clk`.
- Inputs are assumed synchronous to `clk`; the block does no synchronization.

## Configuration
- `GAME_CTRL_HISCORE_EN` defined:
  - Each cycle, if `score_bcd` > `hiscore_bcd` (BCD compare), then `hiscore_bcd` ← `score_bcd`.
  - The high score survives returns to MENU; only `rst_n` clears it.
- Not defined:
  - `hiscore_bcd` is the constant 0 and no register is built.

## Test plan
- **Reset and start:** release reset, then `btn_any_tick` → next cycle `state`=1, `snd_req`=1, `snd_type`=0. Then `snd_ack` for 1 cycle → `snd_req`=0.
- **Progress and no re-scoring:** in PLAYING, up, up, down, up → `frog_row`=2, `score_bcd`=0x002. Up and down in the same cycle → no change.
- **Level clear:** 12 up ticks at level 1 → `level`=2, `frog_row`=0, `score_bcd`=0x022, `snd_type`=1.
- **Crash:**
  - Assert `collision` together with `btn_up_tick` → `state`=2, `frog_row` unchanged, `snd_type`=2.
  - 119 `frame_tick` pulses → still DEAD; the 120th → MENU, `score_bcd`=0.
  - With the macro defined, `hiscore_bcd` keeps the pre-crash score.
- **Win and saturation:**
  - `MAX_LEVEL`=1 → 12 up ticks → `state`=3, `snd_type`=3, `frog_row`=12.
  - Preload score 995 via repeated play: a +10 bonus gives 999.
- **Sound overwrite and async reset:**
  - CRASH pending, no ack, then a NEXTLEVEL event → `snd_type`=1, `snd_req` still 1.
  - Drop `rst_n` between clock edges → all outputs reset immediately.
